// File: rtl/vga_sync_gen.sv
// VGA raster timing: cascaded pixel/line counters with registered sync, video-enable,
// coordinate and strobe outputs. Define VGA_FRAME_CNT_EN to add the frame_cnt output.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic       clk,
  input  logic       clr,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Level driven on hsync/vsync while the pulse is asserted.
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [9:0] hcnt, vcnt;
  logic       h_wrap, v_wrap;

  logic       video_nxt, hsync_nxt, vsync_nxt, line_nxt, frame_nxt;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // NOTE: clr is asynchronous, so it appears in the sensitivity list; all state
  // updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (h_wrap) begin
        hcnt <= '0;
        if (v_wrap) vcnt <= '0;
        else        vcnt <= vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Decode the current counter position; registering it below keeps every output
  // one cycle behind the counters and aligned with x/y.
  always_comb begin
    video_nxt = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
    hsync_nxt = ((hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_nxt = ((vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
    line_nxt  = (hcnt == 10'd0);
    frame_nxt = (hcnt == 10'd0) && (vcnt == 10'd0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x           <= '0;
      y           <= '0;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= hcnt;
      y           <= vcnt;
      video_on    <= video_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Steps on the same edge that registers frame_start, so it reads 1 in the first frame.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)            frame_cnt <= '0;
    else if (frame_nxt) frame_cnt <= frame_cnt + 1'b1;
  end
`else
  // FRAME_W only sizes the optional counter; a zero width is never meaningful.
  if (FRAME_W == 0) begin : g_frame_w_zero
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a default-timing instance and a small-raster,
// active-high-sync instance, each checked against a bench-side raster model every cycle.
module tb_vga_sync_gen;

  // Small raster for the second instance: 16 x 12 = 192 cycles per frame.
  localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int SV_A = 6, SV_F = 2, SV_S = 2, SV_B = 2;
  localparam int S_FRAME = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
  } rast_t;

  typedef struct {
    rast_t      r;
    logic [7:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic clr_d, clr_s;

  logic       hs_d, vs_d, vid_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic       hs_s, vs_s, vid_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fc_d;
  logic [1:0] fc_s;
`endif

  int total = 0;
  int bad   = 0;

  exp_t q_d[$];
  exp_t q_s[$];
  int   hm_d, vm_d, hm_s, vm_s;
  logic [7:0] fm_d, fm_s;
  int   cyc_s, last_fs_s;

  always #5 clk = ~clk;

  vga_sync_gen dut_d (
    .clk(clk), .clr(clr_d), .hsync(hs_d), .vsync(vs_d), .video_on(vid_d),
    .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1), .FRAME_W(2)
  ) dut_s (
    .clk(clk), .clr(clr_s), .hsync(hs_s), .vsync(vs_s), .video_on(vid_s),
    .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
    end
  endtask

  function automatic rast_t model_out(input int h, input int v, input int ha, input int hf,
                                      input int hs, input int va, input int vf, input int vs,
                                      input bit pol);
    rast_t o;
    bit    hact, vact;
    hact          = (h >= ha + hf) && (h < ha + hf + hs);
    vact          = (v >= va + vf) && (v < va + vf + vs);
    o.x           = 10'(h);
    o.y           = 10'(v);
    o.video_on    = (h < ha) && (v < va);
    o.hsync       = pol ? hact : !hact;
    o.vsync       = pol ? vact : !vact;
    o.line_start  = (h == 0);
    o.frame_start = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic rast_t reset_out(input bit pol);
    rast_t o;
    o             = '0;
    o.hsync       = !pol;
    o.vsync       = !pol;
    return o;
  endfunction

  function automatic rast_t act_d();
    return '{x: x_d, y: y_d, video_on: vid_d, hsync: hs_d, vsync: vs_d,
             line_start: ls_d, frame_start: fs_d};
  endfunction

  function automatic rast_t act_s();
    return '{x: x_s, y: y_s, video_on: vid_s, hsync: hs_s, vsync: vs_s,
             line_start: ls_s, frame_start: fs_s};
  endfunction

  // One clock: model pushes what the edge should register, checker pops it on the falling edge.
  task automatic step();
    exp_t e;
    rast_t a;
    @(posedge clk);
    if (!clr_d) begin
      e.r = model_out(hm_d, vm_d, 640, 16, 96, 480, 10, 2, 1'b0);
      if (e.r.frame_start) fm_d = fm_d + 8'd1;
      e.fcnt = fm_d;
      q_d.push_back(e);
      hm_d++;
      if (hm_d == 800) begin hm_d = 0; vm_d++; if (vm_d == 525) vm_d = 0; end
    end
    if (!clr_s) begin
      e.r = model_out(hm_s, vm_s, SH_A, SH_F, SH_S, SV_A, SV_F, SV_S, 1'b1);
      if (e.r.frame_start) fm_s = 8'((fm_s + 8'd1) % 4);
      e.fcnt = fm_s;
      q_s.push_back(e);
      hm_s++;
      if (hm_s == SH_A + SH_F + SH_S + SH_B) begin
        hm_s = 0; vm_s++;
        if (vm_s == SV_A + SV_F + SV_S + SV_B) vm_s = 0;
      end
    end
    @(negedge clk);

    a = act_d();
    if (clr_d) begin
      check("d_reset", a, reset_out(1'b0));
    end else if (q_d.size() == 0) begin
      check("d_q_underrun", q_d.size(), 1);
    end else begin
      e = q_d.pop_front();
      check("d_raster", a, e.r);
`ifdef VGA_FRAME_CNT_EN
      check("d_frame_cnt", fc_d, e.fcnt);
`endif
      if (e.r.y < 480 && e.r.x == 639) check("d_vid_639", a.video_on, 1);
      if (e.r.x == 640) check("d_vid_640", a.video_on, 0);
      if (e.r.x == 655) check("d_hs_655", a.hsync, 1);
      if (e.r.x == 656) check("d_hs_656", a.hsync, 0);
      if (e.r.x == 751) check("d_hs_751", a.hsync, 0);
      if (e.r.x == 752) check("d_hs_752", a.hsync, 1);
      if (e.r.x == 0 && e.r.y != 0) check("d_line_wrap", {a.line_start, a.frame_start}, 2'b10);
    end

    a = act_s();
    if (clr_s) begin
      check("s_reset", a, reset_out(1'b1));
    end else if (q_s.size() == 0) begin
      check("s_q_underrun", q_s.size(), 1);
    end else begin
      e = q_s.pop_front();
      check("s_raster", a, e.r);
`ifdef VGA_FRAME_CNT_EN
      check("s_frame_cnt", fc_s, e.fcnt[1:0]);
`endif
      if (a.frame_start) begin
        if (last_fs_s >= 0) check("s_frame_period", cyc_s - last_fs_s, S_FRAME);
        last_fs_s = cyc_s;
      end
      cyc_s++;
    end
  endtask

  initial begin
    clr_d = 1'b1; clr_s = 1'b1;
    hm_d = 0; vm_d = 0; hm_s = 0; vm_s = 0;
    fm_d = '0; fm_s = '0;
    cyc_s = 0; last_fs_s = -1;

    repeat (5) step();
    #1;
    clr_d = 1'b0; clr_s = 1'b0;

    step();
    check("first_d", {vid_d, ls_d, fs_d, x_d, y_d}, {3'b111, 20'd0});
    check("first_s", {vid_s, ls_s, fs_s, x_s, y_s}, {3'b111, 20'd0});

    // 16301 edges since release puts (300,20) on the outputs.
    repeat (16300) step();
    check("pre_rst_xy", {x_d, y_d}, {10'd300, 10'd20});

    #1;
    clr_d = 1'b1;
    #1;
    check("midrst_async", act_d(), reset_out(1'b0));
    hm_d = 0; vm_d = 0; fm_d = '0;
    q_d.delete();

    repeat (3) step();
    #1;
    clr_d = 1'b0;
    step();
    check("restart_d", {vid_d, ls_d, fs_d, x_d, y_d}, {3'b111, 20'd0});

    repeat (1700) step();
    check("d_q_drained", q_d.size(), 0);
    check("s_q_drained", q_s.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
